// File: rtl/rx_fs4_downconverter.sv
// fs/4 quadrature downconverter: routes the real passband stream into I/Q by NCO
// phase, integrates each branch over a DECIM-clock window and dumps the average.
module rx_fs4_downconverter #(
    parameter int DECIM     = 4,
    parameter int LOG2_HALF = 1
) (
    input  logic               clk,
    input  logic               reset,
    input  logic signed [17:0] rx_in,
    input  logic [1:0]         phase_sel,
    input  logic               resync,
    output logic signed [17:0] i_out,
    output logic signed [17:0] q_out,
    output logic               out_valid,
    output logic               clip
);
    localparam int ACC_W = 18 + LOG2_HALF;
    localparam int CNT_W = (DECIM > 2) ? $clog2(DECIM) : 1;
    localparam logic [CNT_W-1:0] LAST = CNT_W'(DECIM - 1);
    localparam logic signed [ACC_W-1:0] ZERO = '0;

    logic [1:0]              phase;
    logic [CNT_W-1:0]        win;
    logic signed [ACC_W-1:0] acc_i, acc_q;

    logic                    neg_sat;
    logic signed [17:0]      neg_x, sel_x;
    logic signed [ACC_W-1:0] term, sum_i, sum_q;

    // Phases 2/3 negate; the most negative code cannot be negated exactly.
    always_comb begin
        neg_sat = (rx_in == 18'sh20000);
        neg_x   = neg_sat ? 18'sh1FFFF : -rx_in;
        sel_x   = phase[1] ? neg_x : rx_in;
        term    = ACC_W'(sel_x);
        sum_i   = acc_i + (phase[0] ? term : ZERO);
        sum_q   = acc_q + (phase[0] ? ZERO : term);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            phase     <= 2'd0;
            win       <= '0;
            acc_i     <= '0;
            acc_q     <= '0;
            i_out     <= '0;
            q_out     <= '0;
            out_valid <= 1'b0;
            clip      <= 1'b0;
        end else if (resync) begin
            phase     <= phase_sel;
            win       <= '0;
            acc_i     <= '0;
            acc_q     <= '0;
            out_valid <= 1'b0;
            clip      <= 1'b0;
        end else begin
            phase <= phase + 2'd1;
            if (phase[1] && neg_sat)
                clip <= 1'b1;
            if (win == LAST) begin
                win       <= '0;
                acc_i     <= '0;
                acc_q     <= '0;
                i_out     <= 18'(sum_i >>> LOG2_HALF);
                q_out     <= 18'(sum_q >>> LOG2_HALF);
                out_valid <= 1'b1;
            end else begin
                win       <= win + CNT_W'(1);
                acc_i     <= sum_i;
                acc_q     <= sum_q;
                out_valid <= 1'b0;
            end
        end
    end
endmodule

// File: tb/tb_rx_fs4_downconverter.sv
// Bench for rx_fs4_downconverter: directed test-plan steps plus random traffic,
// checked every cycle against a window-sum reference model.
module tb_rx_fs4_downconverter;
    localparam int DECIM     = 4;
    localparam int LOG2_HALF = 1;
    localparam int HALF      = DECIM / 2;

    logic               clk = 1'b0;
    logic               reset = 1'b1;
    logic signed [17:0] rx_in = '0;
    logic [1:0]         phase_sel = '0;
    logic               resync = 1'b0;
    logic signed [17:0] i_out, q_out;
    logic               out_valid, clip;

    int compared = 0;
    int mismatched = 0;

    // reference model state
    int m_phase, m_n, m_si, m_sq, m_i, m_q;
    bit m_v, m_clip;

    rx_fs4_downconverter #(.DECIM(DECIM), .LOG2_HALF(LOG2_HALF)) dut (
        .clk(clk), .reset(reset), .rx_in(rx_in), .phase_sel(phase_sel),
        .resync(resync), .i_out(i_out), .q_out(q_out),
        .out_valid(out_valid), .clip(clip)
    );

    always #5 clk = ~clk;

    function automatic int fdiv(input int a, input int d);
        if (a >= 0) return a / d;
        return -((-a + d - 1) / d);
    endfunction

    task automatic chk(input string tag, input logic signed [31:0] got,
                       input logic signed [31:0] exp);
        compared++;
        assert (got === exp) else begin
            mismatched++;
            $error("FAIL %s: observed %0d expected %0d", tag, got, exp);
        end
    endtask

    // Baseband recovery rule: phase k carries Q (even k) or I (odd k), negated for k>=2.
    task automatic model(input int x, input bit rs, input bit rst, input int ps);
        int c;
        if (rst) begin
            m_phase = 0; m_n = 0; m_si = 0; m_sq = 0;
            m_i = 0; m_q = 0; m_v = 0; m_clip = 0;
        end else if (rs) begin
            m_phase = ps; m_n = 0; m_si = 0; m_sq = 0; m_v = 0; m_clip = 0;
        end else begin
            c = x;
            if (m_phase >= 2) begin
                c = -x;
                if (c > 131071) begin
                    c = 131071;
                    m_clip = 1;
                end
            end
            if (m_phase % 2 == 1) m_si += c;
            else                  m_sq += c;
            m_n++;
            m_v = 0;
            if (m_n == DECIM) begin
                m_i = fdiv(m_si, HALF);
                m_q = fdiv(m_sq, HALF);
                m_v = 1;
                m_n = 0; m_si = 0; m_sq = 0;
            end
            m_phase = (m_phase + 1) % 4;
        end
    endtask

    task automatic cyc(input int x, input bit rs = 0, input bit rst = 0,
                       input int ps = 0);
        rx_in = 18'(x);
        resync = rs;
        reset = rst;
        phase_sel = 2'(ps);
        @(posedge clk);
        model(x, rs, rst, ps);
        #1;
        chk("model_valid", out_valid, m_v);
        chk("model_i", i_out, m_i);
        chk("model_q", q_out, m_q);
        chk("model_clip", clip, m_clip);
    endtask

    task automatic stream4();
        cyc(-500); cyc(1000); cyc(500); cyc(-1000);
    endtask

    initial begin
        int x;
        bit rs, rst;

        // reset state
        cyc(0, 0, 1);
        cyc(0, 0, 1);
        chk("rst_i", i_out, 0);
        chk("rst_q", q_out, 0);
        chk("rst_valid", out_valid, 0);
        chk("rst_clip", clip, 0);

        // aligned demod: first strobe on the 4th clock after reset
        cyc(-500); cyc(1000); cyc(500);
        chk("align_no_early_strobe", out_valid, 0);
        cyc(-1000);
        chk("align_valid", out_valid, 1);
        chk("align_i", i_out, 1000);
        chk("align_q", q_out, -500);
        stream4();
        chk("align_repeat_valid", out_valid, 1);
        chk("align_repeat_i", i_out, 1000);
        chk("align_clip", clip, 0);

        // 180-degree phase offset via resync
        cyc(7, 1, 0, 2);
        stream4();
        chk("phase2_valid", out_valid, 1);
        chk("phase2_i", i_out, -1000);
        chk("phase2_q", q_out, 500);

        // saturation of the negative full-scale code
        cyc(0, 1, 0, 0);
        cyc(-131072); cyc(-131072);
        chk("sat_clip_before", clip, 0);
        cyc(-131072);
        chk("sat_clip_set", clip, 1);
        cyc(-131072);
        chk("sat_i", i_out, -1);
        chk("sat_q", q_out, -1);
        stream4();
        chk("sat_clip_sticky", clip, 1);
        cyc(0, 1, 0, 0);
        chk("sat_clip_cleared", clip, 0);

        // truncation toward minus infinity
        cyc(0); cyc(3); cyc(0); cyc(0);
        chk("trunc_pos_i", i_out, 1);
        cyc(0); cyc(-3); cyc(0); cyc(0);
        chk("trunc_neg_i", i_out, -2);
        chk("trunc_neg_q", q_out, 0);

        // resync on the final window cycle drops that window
        stream4();
        cyc(40); cyc(40); cyc(40);
        cyc(40, 1, 0, 0);
        chk("rs_last_no_valid", out_valid, 0);
        chk("rs_last_hold_i", i_out, 1000);
        chk("rs_last_hold_q", q_out, -500);
        cyc(-500); cyc(1000); cyc(500);
        chk("rs_last_no_early", out_valid, 0);
        cyc(-1000);
        chk("rs_last_strobe", out_valid, 1);

        // resync held for several cycles
        cyc(9, 1, 0, 1); cyc(9, 1, 0, 3); cyc(9, 1, 0, 0);
        stream4();
        chk("rs_hold_i", i_out, 1000);
        chk("rs_hold_q", q_out, -500);

        // reset mid-window (counter = 2)
        cyc(2000); cyc(2000);
        cyc(2000, 0, 1);
        chk("midrst_i", i_out, 0);
        chk("midrst_q", q_out, 0);
        chk("midrst_valid", out_valid, 0);
        cyc(-500); cyc(1000); cyc(500);
        chk("midrst_no_early", out_valid, 0);
        cyc(-1000);
        chk("midrst_valid_after", out_valid, 1);
        chk("midrst_i_after", i_out, 1000);

        // random traffic with sporadic resync/reset and extreme codes
        for (int k = 0; k < 600; k++) begin
            if ($urandom_range(0, 9) == 0) x = -131072;
            else x = int'($urandom_range(0, 262143)) - 131072;
            rs  = ($urandom_range(0, 19) == 0);
            rst = ($urandom_range(0, 99) == 0);
            cyc(x, rs, rst, int'($urandom_range(0, 3)));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end
endmodule

// File: doc/rx_fs4_downconverter.md
# rx_fs4_downconverter

Receive-side quadrature downconverter for the fs/4 modem link. It consumes the real 18-bit passband stream produced by the transmitter, which interleaves I and Q onto a carrier at clk/4, and recovers baseband I and Q. It then averages each branch over a DECIM-clock window and emits one I/Q pair per window with a valid strobe. Downstream it feeds the receive matched filter and symbol timing logic.

## Interface
- DECIM, 4: clocks per output dump window; even power of two, 2..16.
- LOG2_HALF, 1: log2(DECIM/2); must match DECIM (1 for 4, 0 for 2, 3 for 16).
- clk  input  1  system clock; one passband sample per clock.
- reset  input  1  synchronous, active-high.
- rx_in  input  18  signed passband sample, 1s17.
- phase_sel  input  2  NCO phase loaded on resync.
- resync  input  1  one-cycle pulse; realigns NCO and restarts the window.
- i_out  output  18  signed averaged in-phase baseband.
- q_out  output  18  signed averaged quadrature baseband.
- out_valid  output  1  one-cycle strobe; i_out/q_out updated this cycle.
- clip  output  1  sticky negation-saturation flag.

## Operation
- Single clock, synchronous active-high reset.
- Phase counter (2 bits) increments every clk and wraps 3→0.
- Per-clock routing by phase:
  - 0: acc_q += x
  - 1: acc_i += x
  - 2: acc_q += −x
  - 3: acc_i += −x
- −x is saturated: −(−131072) = +131071. Any saturating negation sets clip.
- Accumulators are signed, 18+LOG2_HALF bits, and cannot overflow (DECIM/2 terms per branch).
- Window counter runs 0..DECIM−1 every clk and wraps.
- When the window counter is at DECIM−1, the current clock's contribution is included in the sum:
  - i_out/q_out ← (acc + contribution) >>> LOG2_HALF (arithmetic shift, truncation toward −∞).
  - out_valid ← 1.
  - Both accumulators are cleared to 0 for the next window.
- Otherwise out_valid ← 0, and i_out/q_out hold their values.
- resync (highest priority after reset):
  - phase ← phase_sel, window counter ← 0, accumulators ← 0, clip ← 0.
  - The sample on that cycle is discarded and out_valid ← 0.
  - i_out/q_out hold.
- With phase_sel = 0 and a transmitter starting at its phase 0 on the same cycle, recovered I/Q equal the transmitted baseband. Offsets of 1/2/3 rotate the constellation by multiples of 90°.

## Timing
- Reset values: i_out = 0, q_out = 0, out_valid = 0, clip = 0, phase = 0, window counter = 0, accumulators = 0.
- Latency: the last sample of a window (clock edge k, counter = DECIM−1) appears on i_out/q_out after edge k+1, with out_valid high for exactly that cycle.
- out_valid period is exactly DECIM clocks with no resync. The first strobe occurs DECIM clocks after reset or resync deasserts.
- resync on the cycle where the counter = DECIM−1: that window is dropped and no strobe is issued.
- resync held high for multiple cycles: re-applied each cycle; the window starts on the first clock after it falls.
- Reset mid-window: all state is cleared and the partial window is lost.
- No combinational path from any input to any output.

## Test plan
- Aligned demod, DECIM=4: after reset, drive repeating rx_in = −500, 1000, 500, −1000 (phases 0..3).
  - Required: first out_valid 4 clocks after reset, i_out = 1000, q_out = −500.
  - Repeats every 4 clocks; clip stays 0.
- Phase offset: resync with phase_sel = 2, then drive the same stream aligned to the resync.
  - Required: i_out = −1000, q_out = 500.
- Saturation: constant rx_in = −131072.
  - Required: i_out = −1, q_out = −1 (−131072 + 131071 = −1, >>>1 = −1).
  - clip = 1 from the first negating phase until the next resync or reset.
- Truncation: per window drive i contributions {3, 0} and q {0, 0}; then i {−3, 0}.
  - Required: i_out = 1, then i_out = −2.
- resync on the final window cycle: assert resync when the counter = 3.
  - Required: no out_valid on the next cycle; i_out/q_out hold; next strobe arrives exactly 4 clocks after resync falls.
- Reset mid-window: assert reset at counter = 2.
  - Required: all outputs 0 the next cycle; next strobe 4 clocks after reset deasserts, containing only post-reset samples.
